// File: rtl/pic24_icsp_engine.sv
// pic24_icsp_engine: ICSP master for PIC24 targets.
// Runs the entry sequence after reset, then SIX / REGOUT commands.
module pic24_icsp_engine #(
  parameter int          CLK_DIV  = 4,
  parameter int          WAIT_CYC = 64,
  parameter logic [31:0] ICSP_KEY = 32'h4D434851
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [23:0] instr,
  input  logic        cmd,
  input  logic        valid,
  output logic        ready,
  output logic        dvalid,
  output logic [15:0] dout,
  output logic        PGCx,
  output logic        PGDx_out,
  input  logic        PGDx_in,
  output logic        PGDx_dir,
  output logic        MCLRn
);

  localparam logic [3:0] S_RST   = 4'd0;
  localparam logic [3:0] S_PULSE = 4'd1;
  localparam logic [3:0] S_P18   = 4'd2;
  localparam logic [3:0] S_KEY   = 4'd3;
  localparam logic [3:0] S_P19   = 4'd4;
  localparam logic [3:0] S_MHI   = 4'd5;
  localparam logic [3:0] S_P7    = 4'd6;
  localparam logic [3:0] S_IDLE  = 4'd7;
  localparam logic [3:0] S_SHIFT = 4'd8;

  localparam int PH_W = $clog2(2*CLK_DIV);
  localparam int WC_W = $clog2(WAIT_CYC+1);

  localparam logic [PH_W-1:0] PH_HI  = PH_W'(CLK_DIV-1);
  localparam logic [PH_W-1:0] PH_END = PH_W'(2*CLK_DIV-1);
  localparam logic [WC_W-1:0] WC_END = WC_W'(WAIT_CYC-1);

  function automatic logic [31:0] rev32(
    input logic [31:0] v
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The shifter sends tx[0] first, so the key is stored bit-reversed.
  localparam logic [31:0] KEY_LSB = rev32(ICSP_KEY);

  logic [3:0]      state;
  logic [WC_W-1:0] wcnt;
  logic [PH_W-1:0] ph;
  logic [5:0]      bitn;
  logic [5:0]      last;
  logic [32:0]     tx;
  logic [15:0]     rx;
  logic            is_rd;
  logic            first;
  logic            buf_full;
  logic            buf_cmd;
  logic [23:0]     buf_instr;

  logic        waiting;
  logic        wdone;
  logic        shifting;
  logic        rd_bit;
  logic [15:0] rx_nxt;

  assign waiting  = (state == S_RST) || (state == S_PULSE) ||
                    (state == S_P18) || (state == S_P19) ||
                    (state == S_P7);
  assign wdone    = (wcnt == WC_END);
  assign shifting = (state == S_KEY) || (state == S_SHIFT);
  assign rd_bit   = (state == S_SHIFT) && is_rd &&
                    (bitn >= 6'd12);
  assign rx_nxt   = {PGDx_in, rx[15:1]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_RST;
      wcnt      <= '0;
      ph        <= '0;
      bitn      <= '0;
      last      <= '0;
      tx        <= '0;
      rx        <= '0;
      is_rd     <= 1'b0;
      first     <= 1'b1;
      buf_full  <= 1'b0;
      buf_cmd   <= 1'b0;
      buf_instr <= '0;
      PGCx      <= 1'b0;
      PGDx_out  <= 1'b0;
      PGDx_dir  <= 1'b1;
      MCLRn     <= 1'b0;
      ready     <= 1'b0;
      dvalid    <= 1'b0;
      dout      <= '0;
    end else begin
      ready  <= 1'b0;
      dvalid <= 1'b0;
      wcnt   <= (waiting && !wdone) ? wcnt + WC_W'(1) : '0;
      if (!shifting) PGDx_out <= 1'b0;
      if (valid && !buf_full) begin
        buf_full  <= 1'b1;
        buf_cmd   <= cmd;
        buf_instr <= instr;
      end
      unique case (state)
        S_RST: if (wdone) begin
          MCLRn <= 1'b1;
          state <= S_PULSE;
        end
        S_PULSE: if (wdone) begin
          MCLRn <= 1'b0;
          state <= S_P18;
        end
        S_P18: if (wdone) begin
          state <= S_KEY;
          tx    <= {1'b0, KEY_LSB};
          last  <= 6'd31;
          is_rd <= 1'b0;
          ph    <= '0;
          bitn  <= '0;
        end
        S_P19: if (wdone) begin
          MCLRn <= 1'b1;
          state <= S_MHI;
        end
        S_MHI: state <= S_P7;
        S_P7: if (wdone) state <= S_IDLE;
        S_IDLE: if (buf_full) begin
          buf_full <= 1'b0;
          is_rd    <= buf_cmd;
          ph       <= '0;
          bitn     <= '0;
          state    <= S_SHIFT;
          if (buf_cmd) begin
            tx   <= 33'h1;
            last <= 6'd27;
          end else if (first) begin
            tx    <= {buf_instr, 9'b0};
            last  <= 6'd32;
            first <= 1'b0;
          end else begin
            tx   <= {5'b0, buf_instr, 4'b0};
            last <= 6'd27;
          end
        end
        S_KEY, S_SHIFT: begin
          ph <= ph + PH_W'(1);
          // Data moves one cycle into the low half, clear of the fall.
          if (ph == '0) PGDx_out <= PGDx_dir & tx[0];
          if (ph == PH_HI) PGCx <= 1'b1;
          if (ph == PH_END) begin
            ph   <= '0;
            PGCx <= 1'b0;
            tx   <= tx >> 1;
            bitn <= bitn + 6'd1;
            if (rd_bit) rx <= rx_nxt;
            if (state == S_SHIFT && is_rd && bitn == 6'd3)
              PGDx_dir <= 1'b0;
            if (bitn == last) begin
              if (state == S_KEY) begin
                state <= S_P19;
              end else begin
                state    <= S_IDLE;
                ready    <= 1'b1;
                PGDx_dir <= 1'b1;
                if (is_rd) begin
                  dout   <= rx_nxt;
                  dvalid <= 1'b1;
                end
              end
            end
          end
        end
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_pic24_icsp_engine.sv
// tb_pic24_icsp_engine: scoreboard bench for the ICSP master.
// Bits seen at PGC falls are queued and matched against expectations.
module tb_pic24_icsp_engine;

  localparam int          D   = 4;
  localparam int          W   = 16;
  localparam logic [31:0] KEY = 32'h4D434851;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [23:0] instr = '0;
  logic        cmd = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic        dvalid;
  logic [15:0] dout;
  logic        PGCx;
  logic        PGDx_out;
  logic        PGDx_in = 1'b0;
  logic        PGDx_dir;
  logic        MCLRn;

  always #5 clk = ~clk;

  pic24_icsp_engine #(
    .CLK_DIV(D),
    .WAIT_CYC(W),
    .ICSP_KEY(KEY)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .instr(instr),
    .cmd(cmd),
    .valid(valid),
    .ready(ready),
    .dvalid(dvalid),
    .dout(dout),
    .PGCx(PGCx),
    .PGDx_out(PGDx_out),
    .PGDx_in(PGDx_in),
    .PGDx_dir(PGDx_dir),
    .MCLRn(MCLRn)
  );

  int cmps = 0;
  int errs = 0;
  int cyc = 0;
  int rel_cyc = 0;

  logic exp_q[$];
  logic obs_q[$];
  logic dir_q[$];
  int   mclr_e[$];

  int rises = 0;
  int rdy_cnt = 0;
  int dv_cnt = 0;
  int dv_bad = 0;
  int first_rise = 0;
  int rdy_cyc = 0;
  logic [15:0] tgt = '0;

  logic pgc_q = 1'b0;
  logic mclr_q = 1'b0;
  logic pgd_h = 1'b0;
  logic dir_h = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer plus target model: target drives VISI after each rise.
  always @(negedge clk) begin
    if (rstn) begin
      if (PGCx) begin
        pgd_h = PGDx_out;
        dir_h = PGDx_dir;
      end
      if (!pgc_q && PGCx) begin
        if (rises == 0) first_rise = cyc;
        if (rises >= 12 && rises < 28) PGDx_in = tgt[rises-12];
        else PGDx_in = 1'b0;
        rises++;
      end
      if (pgc_q && !PGCx) begin
        obs_q.push_back(pgd_h);
        dir_q.push_back(dir_h);
      end
      if (ready) begin
        rdy_cnt++;
        rdy_cyc = cyc;
        rises = 0;
      end
      if (dvalid) begin
        dv_cnt++;
        if (!ready) dv_bad++;
      end
    end else begin
      rises = 0;
      PGDx_in = 1'b0;
    end
    if (MCLRn !== mclr_q) begin
      mclr_e.push_back(cyc);
      if (MCLRn) rises = 0;
    end
    pgc_q = PGCx;
    mclr_q = MCLRn;
  end

  task automatic issue(input logic c, input logic [23:0] ins);
    valid = 1'b1;
    cmd = c;
    instr = ins;
    @(negedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic push_six(input logic [23:0] ins, input bit fst);
    int nz = fst ? 9 : 4;
    for (int i = 0; i < nz; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < 24; i++) exp_q.push_back(ins[i]);
  endtask

  task automatic pop_bits(input int n,
                          output logic [32:0] e,
                          output logic [32:0] o);
    e = '0;
    o = '0;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() > 0) e[i] = exp_q.pop_front();
      if (obs_q.size() > 0) o[i] = obs_q.pop_front();
    end
  endtask

  task automatic pop_dir(input int n, output logic [32:0] o);
    o = '0;
    for (int i = 0; i < n; i++)
      if (dir_q.size() > 0) o[i] = dir_q.pop_front();
  endtask

  task automatic wait_rdy(input int n, input int budget,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (rdy_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rstn = 1'b0;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    got = {PGCx, PGDx_out, PGDx_dir, MCLRn, ready, dvalid};
    cmps++;
    if (got !== 6'b001000) begin
      errs++;
      $display("FAIL reset_outs got=%b want=001000", got);
    end
    cmps++;
    if (dout !== 16'h0) begin
      errs++;
      $display("FAIL reset_dout got=%h want=0000", dout);
    end
    mclr_e.delete();
    obs_q.delete();
    dir_q.delete();
    exp_q.delete();
    for (int i = 31; i >= 0; i--) exp_q.push_back(KEY[i]);
    rstn = 1'b1;
    rel_cyc = cyc;
    issue(1'b0, 24'h040200);
    push_six(24'h040200, 1'b1);
  endtask

  task automatic test_entry();
    logic [32:0] e, o;
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (mclr_e.size() >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    cmps++;
    if (!ok) begin
      errs++;
      $display("FAIL entry_timeout edges=%0d want=3", mclr_e.size());
      return;
    end
    cmps++;
    if (mclr_e[0] - rel_cyc != W) begin
      errs++;
      $display("FAIL mclr_low got=%0d want=%0d",
               mclr_e[0] - rel_cyc, W);
    end
    cmps++;
    if (mclr_e[1] - mclr_e[0] != W) begin
      errs++;
      $display("FAIL mclr_pulse got=%0d want=%0d",
               mclr_e[1] - mclr_e[0], W);
    end
    cmps++;
    if (obs_q.size() != 32) begin
      errs++;
      $display("FAIL key_clocks got=%0d want=32", obs_q.size());
    end
    pop_bits(32, e, o);
    cmps++;
    if (o !== e) begin
      errs++;
      $display("FAIL key_bits got=%h want=%h", o, e);
    end
  endtask

  task automatic test_first_six();
    logic [32:0] e, o;
    bit ok;
    wait_rdy(1, 3000, ok);
    cmps++;
    if (!ok) begin
      errs++;
      $display("FAIL six1_timeout got=0 want=1");
      return;
    end
    cmps++;
    if (obs_q.size() != 33) begin
      errs++;
      $display("FAIL six1_clocks got=%0d want=33", obs_q.size());
    end
    pop_bits(33, e, o);
    cmps++;
    if (o !== e) begin
      errs++;
      $display("FAIL six1_bits got=%h want=%h", o, e);
    end
    cmps++;
    if (rdy_cyc - first_rise != 65 * D) begin
      errs++;
      $display("FAIL six1_latency got=%0d want=%0d",
               rdy_cyc - first_rise, 65 * D);
    end
    cmps++;
    if (dv_cnt != 0) begin
      errs++;
      $display("FAIL six1_dvalid got=%0d want=0", dv_cnt);
    end
    dir_q.delete();
  endtask

  task automatic test_six();
    logic [32:0] e, o;
    int prev = rdy_cyc;
    bit ok;
    issue(1'b0, 24'hBA0BB6);
    push_six(24'hBA0BB6, 1'b0);
    wait_rdy(2, 1000, ok);
    cmps++;
    if (!ok) begin
      errs++;
      $display("FAIL six2_timeout got=0 want=1");
      return;
    end
    cmps++;
    if (obs_q.size() != 28) begin
      errs++;
      $display("FAIL six2_clocks got=%0d want=28", obs_q.size());
    end
    pop_bits(28, e, o);
    cmps++;
    if (o !== e) begin
      errs++;
      $display("FAIL six2_bits got=%h want=%h", o, e);
    end
    pop_dir(28, o);
    cmps++;
    if (o !== 33'h0FFFFFFF) begin
      errs++;
      $display("FAIL six2_dir got=%h want=0fffffff", o);
    end
    cmps++;
    if (first_rise - prev != D + 2) begin
      errs++;
      $display("FAIL six2_start got=%0d want=%0d",
               first_rise - prev, D + 2);
    end
    cmps++;
    if (rdy_cyc - first_rise != 55 * D) begin
      errs++;
      $display("FAIL six2_latency got=%0d want=%0d",
               rdy_cyc - first_rise, 55 * D);
    end
  endtask

  task automatic test_regout();
    logic [32:0] e, o;
    bit ok;
    tgt = 16'hFF00;
    issue(1'b1, 24'hABCDEF);
    exp_q.push_back(1'b1);
    for (int i = 0; i < 27; i++) exp_q.push_back(1'b0);
    wait_rdy(3, 1000, ok);
    cmps++;
    if (!ok) begin
      errs++;
      $display("FAIL rd_timeout got=0 want=1");
      return;
    end
    cmps++;
    if (obs_q.size() != 28) begin
      errs++;
      $display("FAIL rd_clocks got=%0d want=28", obs_q.size());
    end
    pop_bits(28, e, o);
    cmps++;
    if (o !== e) begin
      errs++;
      $display("FAIL rd_pgd got=%h want=%h", o, e);
    end
    pop_dir(28, o);
    cmps++;
    if (o !== 33'h0000000F) begin
      errs++;
      $display("FAIL rd_dir got=%h want=0000000f", o);
    end
    cmps++;
    if (dout !== 16'hFF00) begin
      errs++;
      $display("FAIL rd_dout got=%h want=ff00", dout);
    end
    cmps++;
    if (dv_cnt != 1 || dv_bad != 0) begin
      errs++;
      $display("FAIL rd_dvalid got=%0d/%0d want=1/0",
               dv_cnt, dv_bad);
    end
    cmps++;
    if (PGDx_dir !== 1'b1) begin
      errs++;
      $display("FAIL rd_dir_end got=%b want=1", PGDx_dir);
    end
    cmps++;
    if (rdy_cyc - first_rise != 55 * D) begin
      errs++;
      $display("FAIL rd_latency got=%0d want=%0d",
               rdy_cyc - first_rise, 55 * D);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e, o;
    int ra;
    bit ok;
    issue(1'b0, 24'h111111);
    push_six(24'h111111, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    issue(1'b0, 24'h222222);
    push_six(24'h222222, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    issue(1'b0, 24'h333333);
    wait_rdy(4, 1000, ok);
    ra = rdy_cyc;
    cmps++;
    if (!ok) begin
      errs++;
      $display("FAIL b2b_a_timeout got=0 want=1");
      return;
    end
    wait_rdy(5, 1000, ok);
    cmps++;
    if (!ok) begin
      errs++;
      $display("FAIL b2b_b_timeout got=0 want=1");
      return;
    end
    cmps++;
    if (first_rise - ra != D + 1) begin
      errs++;
      $display("FAIL b2b_start got=%0d want=%0d",
               first_rise - ra, D + 1);
    end
    repeat (600) @(negedge clk);
    #1;
    cmps++;
    if (rdy_cnt != 5) begin
      errs++;
      $display("FAIL b2b_ready got=%0d want=5", rdy_cnt);
    end
    cmps++;
    if (obs_q.size() != 56) begin
      errs++;
      $display("FAIL b2b_clocks got=%0d want=56", obs_q.size());
    end
    pop_bits(28, e, o);
    cmps++;
    if (o !== e) begin
      errs++;
      $display("FAIL b2b_a_bits got=%h want=%h", o, e);
    end
    pop_bits(28, e, o);
    cmps++;
    if (o !== e) begin
      errs++;
      $display("FAIL b2b_b_bits got=%h want=%h", o, e);
    end
    cmps++;
    if (mclr_e.size() != 3 || MCLRn !== 1'b1) begin
      errs++;
      $display("FAIL mclr_hold got=%0d/%b want=3/1",
               mclr_e.size(), MCLRn);
    end
    dir_q.delete();
  endtask

  task automatic test_midreset();
    logic [5:0] got;
    bit ok = 1'b0;
    tgt = 16'h1234;
    issue(1'b1, 24'h0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (rises >= 16) begin
        ok = 1'b1;
        break;
      end
    end
    cmps++;
    if (!ok) begin
      errs++;
      $display("FAIL mid_timeout got=%0d want=16", rises);
    end
    rstn = 1'b0;
    #1;
    got = {PGCx, PGDx_out, PGDx_dir, MCLRn, ready, dvalid};
    cmps++;
    if (got !== 6'b001000) begin
      errs++;
      $display("FAIL mid_outs got=%b want=001000", got);
    end
    cmps++;
    if (dout !== 16'h0) begin
      errs++;
      $display("FAIL mid_dout got=%h want=0000", dout);
    end
    repeat (3) @(negedge clk);
    #1;
    mclr_e.delete();
    obs_q.delete();
    dir_q.delete();
    exp_q.delete();
    rstn = 1'b1;
    rel_cyc = cyc;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (mclr_e.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    cmps++;
    if (!ok) begin
      errs++;
      $display("FAIL mid_reentry got=%0d want=2", mclr_e.size());
      return;
    end
    cmps++;
    if (mclr_e[0] - rel_cyc != W || mclr_e[1] - mclr_e[0] != W) begin
      errs++;
      $display("FAIL mid_restart got=%0d/%0d want=%0d/%0d",
               mclr_e[0] - rel_cyc, mclr_e[1] - mclr_e[0], W, W);
    end
    cmps++;
    if (rdy_cnt != 5 || dv_cnt != 1) begin
      errs++;
      $display("FAIL mid_abort got=%0d/%0d want=5/1",
               rdy_cnt, dv_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_first_six();
    test_six();
    test_regout();
    test_back_to_back();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmps, errs);
    $finish;
  end

endmodule
